// File: rtl/instr_seq_pkg.sv
// Shared types, widths and opcode constants for the two-cycle instruction sequencer.
package instr_seq_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OP_W-1:0] OP_BT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_BF   = 4'b1000;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

  // Immediate value that tells the ALU to use the register operand.
  localparam logic [INST_W-1:0] IMM_REG_SEL = 9'h100;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Pure combinational split of a 9-bit instruction word into ALU fields and class flags.
module instr_decode
  import instr_seq_pkg::*;
(
  input  logic [INST_W-1:0] Inst_in,
  output logic [OP_W-1:0]   Op,
  output logic [INST_W-1:0] Immediate,
  output logic [3:0]        Reg_idx,
  output logic              is_add,
  output logic              is_branch,
  output logic              is_halt
);

  logic [OP_W-1:0] op_field_s;

  assign op_field_s = Inst_in[7:4];

  // Field extraction: bit 8 distinguishes register-form from immediate-form words.
  always_comb begin
    Op        = OP_NOP;
    Immediate = IMM_REG_SEL;
    Reg_idx   = 4'd0;
    is_add    = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    if (Inst_in[8]) begin
      Op        = op_field_s;
      Reg_idx   = Inst_in[3:0];
      Immediate = IMM_REG_SEL;
      is_add    = (op_field_s == OP_ADD);
      is_branch = (op_field_s == OP_BT) || (op_field_s == OP_BF);
      is_halt   = (op_field_s == OP_HALT);
    end else begin
      Op        = OP_NOP;
      Reg_idx   = 4'd0;
      Immediate = Inst_in;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute controller: owns PC, carry feedback and executed-instruction counter,
// and presents the decoded ALU controls only while an instruction is executing.
module instr_sequencer
  import instr_seq_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [INST_W-1:0] Inst_in,
  input  logic              Branch,
  input  logic [PC_W-1:0]   Target,
  input  logic              Ovf_alu,
  output logic [PC_W-1:0]   Inst_addr,
  output logic [OP_W-1:0]   Op,
  output logic [INST_W-1:0] Immediate,
  output logic [3:0]        Reg_idx,
  output logic              Exec_en,
  output logic              Ovf_q,
  output logic              Done,
  output logic [CNT_W-1:0]  Inst_count
);

  state_t             state_r;
  logic [PC_W-1:0]    pc_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   count_r;
  logic               done_r;

  logic [OP_W-1:0]    dec_op_s;
  logic [INST_W-1:0]  dec_imm_s;
  logic [3:0]         dec_reg_s;
  logic               is_add_s;
  logic               is_branch_s;
  logic               is_halt_s;
  logic               in_exec_s;

  instr_decode u_decode (
    .Inst_in   (Inst_in),
    .Op        (dec_op_s),
    .Immediate (dec_imm_s),
    .Reg_idx   (dec_reg_s),
    .is_add    (is_add_s),
    .is_branch (is_branch_s),
    .is_halt   (is_halt_s)
  );

  assign in_exec_s = (state_r == ST_EXEC);

  // ROM data only becomes valid in EXEC, so the ALU controls are gated by the registered state.
  always_comb begin
    Op        = OP_NOP;
    Immediate = IMM_REG_SEL;
    Reg_idx   = 4'd0;
    Exec_en   = 1'b0;
    if (in_exec_s) begin
      Op        = dec_op_s;
      Immediate = dec_imm_s;
      Reg_idx   = dec_reg_s;
      Exec_en   = ~is_halt_s;
    end else begin
      Op        = OP_NOP;
      Immediate = IMM_REG_SEL;
      Reg_idx   = 4'd0;
      Exec_en   = 1'b0;
    end
  end

  // Main FSM with PC, carry and counter state; the halt word leaves PC where it is.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      pc_r    <= 8'd0;
      ovf_r   <= 1'b0;
      count_r <= 16'd0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (Start) begin
            state_r <= ST_FETCH;
            pc_r    <= 8'd0;
            ovf_r   <= 1'b0;
            count_r <= 16'd0;
            done_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_halt_s) begin
            state_r <= ST_HALT;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
            pc_r    <= (is_branch_s && Branch) ? Target : pc_r + 8'd1;
            count_r <= sat_inc(count_r);
            if (is_add_s) begin
              ovf_r <= Ovf_alu;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Inst_addr  = pc_r;
  assign Ovf_q      = ovf_r;
  assign Inst_count = count_r;
  assign Done       = done_r;

endmodule
